// File: rtl/core_seq_pkg.sv
// Shared encodings for the RV32 core phase sequencer: datapath phases and
// run-control states.
package core_seq_pkg;

    typedef enum logic [2:0] {
        PH_FETCH = 3'd0,
        PH_DEC   = 3'd1,
        PH_EXE   = 3'd2,
        PH_MEM   = 3'd3,
        PH_WB    = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ctrl_state_e;

    // Phase successor; WRITEBACK wraps to FETCH so 5..7 are never produced.
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_FETCH: n = PH_DEC;
            PH_DEC:   n = PH_EXE;
            PH_EXE:   n = PH_MEM;
            PH_MEM:   n = PH_WB;
            default:  n = PH_FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Front-panel button conditioner: a level change is accepted only after it has
// been stable for DEBOUNCE_CYCLES samples; each accepted press gives one pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          stable;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable      <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (btn_in != stable) begin
                if (cnt == LAST) begin
                    stable      <= btn_in;
                    cnt         <= '0;
                    press_pulse <= btn_in;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/core_phase_sequencer.sv
// Phase sequencer for the multi-cycle RV32 core: run/halt/step control,
// memory wait-state stalling with timeout, and retired-instruction counting.
module core_phase_sequencer
    import core_seq_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MEM_TIMEOUT     = 255,
    parameter bit START_RUNNING   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic [2:0]       phase,
    output logic             phase_en,
    output logic             stalled,
    output logic             running,
    output logic             halted,
    output logic [WIDTH-1:0] retired,
    output logic             mem_timeout_err
);

    localparam int SCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [SCW-1:0] STALL_LIMIT = SCW'(MEM_TIMEOUT);
    localparam ctrl_state_e RESET_STATE = START_RUNNING ? ST_RUN : ST_HALT;

    ctrl_state_e    state, state_next;
    phase_e         phase_q;
    logic [SCW-1:0] stall_cnt;
    logic           pending_halt;
    logic           run_press, step_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (run_btn),
        .press_pulse (run_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (step_btn),
        .press_pulse (step_press)
    );

    // mem_ready and halt_req only matter in their own phases.
    logic mem_wait, stall_now, timed_out, wb_adv, halt_trigger, halt_due;
    assign mem_wait     = (phase_q == PH_MEM) && mem_access && !mem_ready;
    assign stall_now    = mem_wait && (stall_cnt < STALL_LIMIT);
    assign timed_out    = mem_wait && (stall_cnt >= STALL_LIMIT);
    assign wb_adv       = phase_en && (phase_q == PH_WB);
    assign halt_trigger = run_press || (halt_req && (phase_q == PH_DEC));
    assign halt_due     = pending_halt || halt_trigger;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_HALT: begin
                if (run_press) begin
                    state_next = ST_RUN;
                end else if (step_press) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN:  if (wb_adv && halt_due) state_next = ST_HALT;
            ST_STEP: if (wb_adv) state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    always_comb begin
        running  = (state != ST_HALT);
        halted   = (state == ST_HALT);
        stalled  = running && stall_now;
        phase_en = running && !stall_now;
    end

    // A halt request in RUN never cuts an instruction short; it waits for WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q         <= PH_FETCH;
            retired         <= '0;
            mem_timeout_err <= 1'b0;
            stall_cnt       <= '0;
            pending_halt    <= 1'b0;
        end else begin
            if (phase_en) begin
                phase_q <= next_phase(phase_q);
            end
            if (wb_adv) begin
                retired <= retired + WIDTH'(1);
            end
            if (timed_out) begin
                mem_timeout_err <= 1'b1;
            end
            if (phase_en) begin
                stall_cnt <= '0;
            end else if (stalled) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((state == ST_RUN) && !wb_adv) begin
                pending_halt <= halt_due;
            end else begin
                pending_halt <= 1'b0;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_core_phase_sequencer.sv
// Self-checking bench for core_phase_sequencer: randomized instruction stream
// checked against instruction-level expectations (length, stall count, retired).
module tb_core_phase_sequencer;

    localparam int W  = 8;
    localparam int DB = 4;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         run_btn, step_btn, halt_req, mem_access, mem_ready;
    logic [2:0]   phase;
    logic         phase_en, stalled, running, halted, mem_timeout_err;
    logic [W-1:0] retired;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_retired;

    core_phase_sequencer #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .MEM_TIMEOUT(TO), .START_RUNNING(1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run_btn         (run_btn),
        .step_btn        (step_btn),
        .halt_req        (halt_req),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .phase           (phase),
        .phase_en        (phase_en),
        .stalled         (stalled),
        .running         (running),
        .halted          (halted),
        .retired         (retired),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one instruction starting at a negedge in FETCH; returns at the negedge
    // after the WRITEBACK advance. Memory stalls for s cycles when acc is set.
    task automatic run_instr(input bit acc, input int s, input bit hreq,
                             output int len, output int nstall, output int nbad);
        int  j;
        bit  done;
        len = 0; nstall = 0; nbad = 0; j = 0; done = 0;
        while (!done && len < 60) begin
            if (phase == 3'd3) begin
                mem_access = acc;
                mem_ready  = (j >= s);
                j++;
            end else begin
                mem_access = 1'($urandom_range(0, 1));
                mem_ready  = 1'($urandom_range(0, 1));
            end
            halt_req = (phase == 3'd1) ? hreq : 1'($urandom_range(0, 1));
            #1;
            if (stalled) nstall++;
            if (phase_en !== !stalled) nbad++;
            if (phase == 3'd4 && phase_en) done = 1;
            len++;
            @(negedge clk);
        end
        mem_access = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run_btn = 0; step_btn = 0; halt_req = 0;
        mem_access = 0; mem_ready = 0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_checks++; if (retired !== '0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        n_checks++; if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", mem_timeout_err); end
        n_checks++; if (halted !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL reset_state: got halted=%0b running=%0b expected 0/1", halted, running); end
        n_checks++; if (stalled !== 1'b0 || phase_en !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got stalled=%0b phase_en=%0b expected 0/1", stalled, phase_en); end
        @(negedge clk);
        reset = 1'b0;
        exp_retired = '0;
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 20; k++) begin
            #1;
            n_checks++; if (phase !== 3'(k % 5)) begin n_fail++; $display("FAIL seq_phase[%0d]: got %0d expected %0d", k, phase, k % 5); end
            n_checks++; if (retired !== W'(k / 5)) begin n_fail++; $display("FAIL seq_retired[%0d]: got %0d expected %0d", k, retired, k / 5); end
            @(negedge clk);
        end
        exp_retired = W'(4);
    endtask

    task automatic test_random_stalls();
        int len, nstall, nbad, s, s_eff;
        bit acc;
        for (int n = 0; n < 270; n++) begin
            acc = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, TO - 1);
            s_eff = acc ? s : 0;
            run_instr(acc, s, 1'b0, len, nstall, nbad);
            exp_retired = exp_retired + W'(1);
            n_checks++; if (len !== 5 + s_eff) begin n_fail++; $display("FAIL instr_len[%0d]: got %0d expected %0d", n, len, 5 + s_eff); end
            n_checks++; if (nstall !== s_eff) begin n_fail++; $display("FAIL stall_cycles[%0d]: got %0d expected %0d", n, nstall, s_eff); end
            n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL en_vs_stall[%0d]: got %0d bad cycles expected 0", n, nbad); end
            n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL retired[%0d]: got %0d expected %0d", n, retired, exp_retired); end
        end
        n_checks++; if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_err: got %0b expected 0", mem_timeout_err); end
    endtask

    task automatic test_timeout();
        int len, nstall, nbad;
        run_instr(1'b1, 1000, 1'b0, len, nstall, nbad);
        exp_retired = exp_retired + W'(1);
        n_checks++; if (nstall !== TO) begin n_fail++; $display("FAIL timeout_stalls: got %0d expected %0d", nstall, TO); end
        n_checks++; if (len !== 5 + TO) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", len, 5 + TO); end
        n_checks++; if (mem_timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0b expected 1", mem_timeout_err); end
        run_instr(1'b0, 0, 1'b0, len, nstall, nbad);
        exp_retired = exp_retired + W'(1);
        n_checks++; if (mem_timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0b expected 1", mem_timeout_err); end
        n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL timeout_retired: got %0d expected %0d", retired, exp_retired); end
    endtask

    task automatic test_halt_step();
        int len, nstall, nbad, en_cnt, run_cnt;
        run_instr(1'b0, 0, 1'b1, len, nstall, nbad);
        exp_retired = exp_retired + W'(1);
        #1;
        n_checks++; if (len !== 5) begin n_fail++; $display("FAIL halt_req_len: got %0d expected 5", len); end
        n_checks++; if (halted !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL halt_req_state: got halted=%0b running=%0b expected 1/0", halted, running); end
        n_checks++; if (phase !== 3'd0 || phase_en !== 1'b0) begin n_fail++; $display("FAIL halt_req_phase: got phase=%0d en=%0b expected 0/0", phase, phase_en); end
        n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL halt_req_retired: got %0d expected %0d", retired, exp_retired); end
        @(negedge clk);
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            halt_req = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
            #1; if (phase_en) en_cnt++;
            @(negedge clk);
        end
        n_checks++; if (en_cnt !== 0) begin n_fail++; $display("FAIL halt_frozen: got %0d enabled cycles expected 0", en_cnt); end
        en_cnt = 0; run_cnt = 0;
        for (int k = 0; k < 3 * DB + 30; k++) begin
            step_btn = (k < 3 * DB);
            halt_req = 1'($urandom_range(0, 1));
            #1; if (phase_en) en_cnt++; if (running) run_cnt++;
            @(negedge clk);
        end
        exp_retired = exp_retired + W'(1);
        #1;
        n_checks++; if (en_cnt !== 5) begin n_fail++; $display("FAIL step_en_cycles: got %0d expected 5", en_cnt); end
        n_checks++; if (run_cnt !== 5) begin n_fail++; $display("FAIL step_active_cycles: got %0d expected 5", run_cnt); end
        n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL step_retired: got %0d expected %0d", retired, exp_retired); end
        n_checks++; if (halted !== 1'b1 || phase !== 3'd0) begin n_fail++; $display("FAIL step_rehalt: got halted=%0b phase=%0d expected 1/0", halted, phase); end
        halt_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bounce_and_run_halt();
        int trans, first_idx, k;
        logic prev_halted;
        bit seen;
        trans = 0; first_idx = -1; prev_halted = 1'b1;
        for (int i = 0; i < 20 + 5 * DB; i++) begin
            if (i < 20) run_btn = ((i / 3) % 2 == 0);
            else        run_btn = (i < 20 + 3 * DB);
            #1;
            if (halted !== prev_halted) begin
                trans++;
                if (first_idx < 0) first_idx = i;
            end
            prev_halted = halted;
            @(negedge clk);
        end
        n_checks++; if (trans !== 1) begin n_fail++; $display("FAIL bounce_transitions: got %0d expected 1", trans); end
        n_checks++; if (first_idx < 20) begin n_fail++; $display("FAIL bounce_accept_time: got cycle %0d expected >= 20", first_idx); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL bounce_running: got halted=%0b expected 0", halted); end
        seen = 0; k = 0;
        while (!seen && k < 60) begin
            run_btn = (k < DB + 2);
            #1;
            if (halted) seen = 1;
            @(negedge clk);
            k++;
        end
        run_btn = 1'b0;
        #1;
        n_checks++; if (!seen || halted !== 1'b1) begin n_fail++; $display("FAIL run_press_halt: got halted=%0b expected 1", halted); end
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL run_press_phase: got %0d expected 0", phase); end
        trans = 0;
        for (int i = 0; i < 2 * DB; i++) begin
            @(negedge clk); #1;
            if (!halted) trans++;
        end
        n_checks++; if (trans !== 0) begin n_fail++; $display("FAIL run_press_stays_halted: got %0d running cycles expected 0", trans); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        int len, nstall, nbad;
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 7; n++) run_instr(1'b0, 0, 1'b0, len, nstall, nbad);
        for (int k = 0; k < 3; k++) begin
            mem_access = 1'b0;
            @(negedge clk);
        end
        mem_access = 1'b1; mem_ready = 1'b0;
        #1;
        n_checks++; if (phase !== 3'd3 || stalled !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got phase=%0d stalled=%0b expected 3/1", phase, stalled); end
        n_checks++; if (retired !== W'(7)) begin n_fail++; $display("FAIL pre_reset_retired: got %0d expected 7", retired); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (phase !== 3'd0 || stalled !== 1'b0) begin n_fail++; $display("FAIL async_reset_phase: got phase=%0d stalled=%0b expected 0/0", phase, stalled); end
        n_checks++; if (retired !== '0) begin n_fail++; $display("FAIL async_reset_retired: got %0d expected 0", retired); end
        n_checks++; if (mem_timeout_err !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got err=%0b halted=%0b expected 0/0", mem_timeout_err, halted); end
        mem_access = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_random_stalls();
        test_timeout();
        test_halt_step();
        test_bounce_and_run_halt();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
